// File: rtl/uart_rx_pkg.sv
// Shared types and timing helpers for the UART receive frame controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Check point: the sampler's majority window around mid-bit has closed.
    function automatic int cp_of(input int prescale);
        return prescale / 2 + 2;
    endfunction

    function automatic int dp_of(input int prescale);
        return prescale - 1;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter (wraps at the decision point) and frame bit counter.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int BIT_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        edge_clr,
    input  logic                        edge_run,
    input  logic                        bit_clr,
    input  logic                        bit_inc,
    output logic [$clog2(PRESCALE)-1:0] edge_cnt,
    output logic [BIT_W-1:0]            bit_cnt,
    output logic                        edge_at_dp
);

    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] DP = EW'(dp_of(PRESCALE));

    logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign edge_at_dp = (edge_cnt_q == DP);

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (edge_clr) begin
            edge_cnt_d = '0;
        end else if (edge_run) begin
            edge_cnt_d = edge_at_dp ? '0 : edge_cnt_q + EW'(1);
        end

        bit_cnt_d = bit_cnt_q;
        if (bit_clr) begin
            bit_cnt_d = '0;
        end else if (bit_inc) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: bit-slot FSM, mid-bit check pulses, frame verdict.
// Optional UART_RX_ERR_CNT_EN adds a saturating frame-error counter (err_cnt/err_clr).
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | start bit slot, start check at CP, glitch abort at DP
// DATA   | data bit slots, LSB first, shift pulse at CP
// PARITY | parity bit slot, verdict latched at DP
// STOP   | stop bit slot, frame verdict at DP
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_in,
    input  logic                        par_en,
    input  logic                        strt_glitch,
    input  logic                        par_err,
    input  logic                        stp_err,
    output logic                        sample_en,
    output logic [$clog2(PRESCALE)-1:0] edge_cnt,
    output logic                        strt_chk_en,
    output logic                        deser_en,
    output logic                        par_chk_en,
    output logic                        stp_chk_en,
    output logic                        data_valid,
    output logic                        frame_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]                  err_cnt,
    input  logic                        err_clr
`endif
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    // Pulses are registered, so they are decoded one edge early to land on CP.
    localparam logic [EW-1:0] CP_PRE   = EW'(cp_of(PRESCALE) - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_e state_q, state_d;
    logic par_en_q, par_en_d;
    logic par_err_q, par_err_d;
    logic sample_en_q, sample_en_d;
    logic strt_chk_en_q, strt_chk_en_d;
    logic deser_en_q, deser_en_d;
    logic par_chk_en_q, par_chk_en_d;
    logic stp_chk_en_q, stp_chk_en_d;
    logic data_valid_q, data_valid_d;
    logic frame_err_q, frame_err_d;

    logic [EW-1:0] edge_cnt_w;
    logic [BW-1:0] bit_cnt_w;
    logic          at_dp;
    logic          at_cp_pre;

    uart_rx_edge_bit_cnt #(
        .PRESCALE(PRESCALE),
        .BIT_W   (BW)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .edge_clr  (state_q == IDLE),
        .edge_run  (state_q != IDLE),
        .bit_clr   (state_q == START),
        .bit_inc   ((state_q == DATA) && at_dp),
        .edge_cnt  (edge_cnt_w),
        .bit_cnt   (bit_cnt_w),
        .edge_at_dp(at_dp)
    );

    assign at_cp_pre = (edge_cnt_w == CP_PRE);

    always_comb begin
        state_d       = state_q;
        par_en_d      = par_en_q;
        par_err_d     = par_err_q;
        strt_chk_en_d = 1'b0;
        deser_en_d    = 1'b0;
        par_chk_en_d  = 1'b0;
        stp_chk_en_d  = 1'b0;
        data_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d   = START;
                    par_en_d  = par_en;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                strt_chk_en_d = at_cp_pre;
                if (at_dp) state_d = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                deser_en_d = at_cp_pre;
                if (at_dp && (bit_cnt_w == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                par_chk_en_d = at_cp_pre;
                if (at_dp) begin
                    par_err_d = par_err;
                    state_d   = STOP;
                end
            end
            STOP: begin
                stp_chk_en_d = at_cp_pre;
                if (at_dp) begin
                    frame_err_d  = par_err_q | stp_err;
                    data_valid_d = ~(par_err_q | stp_err);
                    if (!rx_in) begin
                        state_d   = START;
                        par_err_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        sample_en_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            par_en_q      <= 1'b0;
            par_err_q     <= 1'b0;
            sample_en_q   <= 1'b0;
            strt_chk_en_q <= 1'b0;
            deser_en_q    <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stp_chk_en_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            par_en_q      <= par_en_d;
            par_err_q     <= par_err_d;
            sample_en_q   <= sample_en_d;
            strt_chk_en_q <= strt_chk_en_d;
            deser_en_q    <= deser_en_d;
            par_chk_en_q  <= par_chk_en_d;
            stp_chk_en_q  <= stp_chk_en_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (frame_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

    assign sample_en   = sample_en_q;
    assign edge_cnt    = edge_cnt_w;
    assign strt_chk_en = strt_chk_en_q;
    assign deser_en    = deser_en_q;
    assign par_chk_en  = par_chk_en_q;
    assign stp_chk_en  = stp_chk_en_q;
    assign data_valid  = data_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (PRESCALE=8, DATA_WIDTH=8) with simple checker models.
module tb_uart_rx_ctrl;

    localparam int PRESCALE   = 8;
    localparam int DATA_WIDTH = 8;
    localparam int CP         = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic       sample_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, frame_err;
    logic [2:0] edge_cnt;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic       err_clr = 1'b0;
`endif

    uart_rx_ctrl #(.PRESCALE(PRESCALE), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .strt_glitch(strt_glitch),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .sample_en  (sample_en),
        .edge_cnt   (edge_cnt),
        .strt_chk_en(strt_chk_en),
        .deser_en   (deser_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .data_valid (data_valid),
        .frame_err  (frame_err)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Checker models: registered verdicts one clock after their enable.
    logic inj_par = 1'b0;
    logic inj_stp = 1'b0;
    always @(posedge clk) begin
        strt_glitch <= strt_chk_en & rx_in;
        par_err     <= par_chk_en & inj_par;
        stp_err     <= stp_chk_en & (~rx_in | inj_stp);
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_deser, n_strt, n_par, n_stp, n_dv, n_fe, dv_cyc, dv_prev, fe_cyc;
    logic [7:0] rx_byte;

    always @(negedge clk) begin
        if (deser_en) begin
            n_deser++;
            rx_byte = {rx_in, rx_byte[7:1]};
            check("deser_en_edge", edge_cnt, CP);
        end
        if (strt_chk_en) n_strt++;
        if (par_chk_en)  n_par++;
        if (stp_chk_en) begin
            n_stp++;
            check("stp_chk_edge", edge_cnt, CP);
        end
        if (data_valid) begin
            n_dv++;
            dv_prev = dv_cyc;
            dv_cyc  = cyc;
        end
        if (frame_err) begin
            n_fe++;
            fe_cyc = cyc;
        end
    end

    task automatic clear_mon();
        n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0;
        n_dv = 0; n_fe = 0; dv_cyc = 0; dv_prev = 0; fe_cyc = 0;
        rx_byte = '0;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (PRESCALE) @(negedge clk);
    endtask

    // t0 is the cycle stamp of the first edge that sees the start bit low.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic stop_b,
                              output int t0);
        par_en = pe;
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_WIDTH; i++) drive_bit(d[i]);
        if (pe) drive_bit(^d);
        drive_bit(stop_b);
        rx_in = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       ip;
        logic       is;
        int         exp_dv;
        int         exp_fe;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        clear_mon();
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1, 0, 80};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 0, 1, 88};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 1, 0, 88};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 0, 1, 80};
        vecs[4] = '{8'h96, 1'b1, 1'b0, 1'b1, 0, 1, 88};
        vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1, 0, 80};

        repeat (3) @(negedge clk);
        check("reset_outputs", {sample_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                                data_valid, frame_err}, 0);
        check("reset_edge_cnt", edge_cnt, 0);
`ifdef UART_RX_ERR_CNT_EN
        check("reset_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            inj_par = vecs[v].ip;
            inj_stp = vecs[v].is;
            send_frame(vecs[v].data, vecs[v].pe, 1'b1, t0);
            repeat (4) @(negedge clk);
            check("vec_deser_cnt", n_deser, DATA_WIDTH);
            check("vec_rx_byte", rx_byte, vecs[v].data);
            check("vec_strt_chk_cnt", n_strt, 1);
            check("vec_par_chk_cnt", n_par, {31'd0, vecs[v].pe});
            check("vec_stp_chk_cnt", n_stp, 1);
            check("vec_data_valid_cnt", n_dv, vecs[v].exp_dv);
            check("vec_frame_err_cnt", n_fe, vecs[v].exp_fe);
            check("vec_latency", (vecs[v].exp_dv != 0 ? dv_cyc : fe_cyc) - t0, vecs[v].exp_lat);
            check("vec_back_idle", sample_en, 0);
            inj_par = 1'b0;
            inj_stp = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Start glitch: line low for only 3 clocks.
        clear_mon();
        par_en = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_still_start", sample_en, 1);
        @(negedge clk);
        check("glitch_idle_after_8", sample_en, 0);
        repeat (4) @(negedge clk);
        check("glitch_strt_chk_cnt", n_strt, 1);
        check("glitch_no_deser", n_deser, 0);
        check("glitch_no_dv_fe", n_dv + n_fe, 0);

        // Back-to-back frames: the second start bit follows the stop bit directly.
        clear_mon();
        send_frame(8'hC3, 1'b0, 1'b1, t0);
        send_frame(8'h81, 1'b0, 1'b1, t0);
        repeat (4) @(negedge clk);
        check("b2b_dv_cnt", n_dv, 2);
        check("b2b_dv_spacing", dv_cyc - dv_prev, 80);
        check("b2b_second_latency", dv_cyc - t0, 80);
        check("b2b_deser_cnt", n_deser, 16);
        check("b2b_rx_byte", rx_byte, 8'h81);
        check("b2b_no_fe", n_fe, 0);

        // Reset in the middle of data bit 4.
        clear_mon();
        par_en = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_data_sample_en", sample_en, 1);
        check("mid_data_edge_cnt", edge_cnt, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {sample_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                                  data_valid, frame_err}, 0);
        check("rst_mid_edge_cnt", edge_cnt, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_stays_idle", sample_en, 0);
        clear_mon();
        send_frame(8'h55, 1'b0, 1'b1, t0);
        repeat (4) @(negedge clk);
        check("post_rst_dv_cnt", n_dv, 1);
        check("post_rst_rx_byte", rx_byte, 8'h55);
        check("post_rst_latency", dv_cyc - t0, 80);

`ifdef UART_RX_ERR_CNT_EN
        clear_mon();
        inj_stp = 1'b1;
        for (int f = 0; f < 300; f++) begin
            send_frame(8'h0F, 1'b0, 1'b1, t0);
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("errcnt_fe_pulses", n_fe, 300);
        check("errcnt_saturated", err_cnt, 255);
        send_frame(8'h0F, 1'b0, 1'b1, t0);
        @(negedge clk);
        check("errcnt_fe_now", frame_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("errcnt_clear_wins", err_cnt, 0);
        inj_stp = 1'b1;
        send_frame(8'h0F, 1'b0, 1'b1, t0);
        repeat (3) @(negedge clk);
        check("errcnt_after_clear", err_cnt, 1);
        inj_stp = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
